l2_prefetch_buf: RTL and testbench

Parametrised line-based L2 prefetch buffer between the CPU read path and the backing-memory fill port. It holds 2^IW data words organised as 2^(IW-LW) direct-mapped lines with per-line tag and valid bits. On a read miss it fetches the whole line from backing memory through a request/beat handshake. CPU writes that hit a buffered line are snooped in, and a bulk clear sweeps all valid bits.

---
 rtl/l2_prefetch_buf_if.sv | 11 +
 rtl/l2_prefetch_buf.sv | 112 +++++++++++
 tb/tb_l2_prefetch_buf.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/l2_prefetch_buf_if.sv
// l2_prefetch_buf_if: CPU lookup/write, backing-memory fill and clear signals of l2_prefetch_buf.
interface l2_prefetch_buf_if #(parameter int AW = 26);
    logic [AW-1:0] RDA, FA, WRA;
    logic RDREQ, Match, BUSY, FREQ, FACK, FDV, WR, CLR;
    logic [31:0] RDD, FD, WRD;
    logic [3:0] WRM;
    modport master (output RDA, RDREQ, FACK, FD, FDV, WRA, WRD, WR, WRM, CLR,
                    input RDD, Match, BUSY, FREQ, FA);
    modport slave (input RDA, RDREQ, FACK, FD, FDV, WRA, WRD, WR, WRM, CLR,
                   output RDD, Match, BUSY, FREQ, FA);
endinterface

// File: rtl/l2_prefetch_buf.sv
// l2_prefetch_buf: direct-mapped line prefetch buffer with line fill, write snoop and bulk clear.
// Define PREFETCH_NEXT_EN to fetch the following line after every demand fill.
module l2_prefetch_buf #(
    parameter int AW = 26,
    parameter int IW = 7,
    parameter int LW = 2
) (
    input logic CLK,
    input logic RST,
    l2_prefetch_buf_if.slave bus
);
    localparam int NL = 1 << (IW - LW);
    localparam int TW = AW - IW;
    typedef enum logic [2:0] {
        CLEAR, IDLE, REQ, DATA,
`ifdef PREFETCH_NEXT_EN
        PF,
`endif
        COMMIT
    } state_t;
    logic [31:0] data [1 << IW];
    logic [TW-1:0] tag [NL];
    logic [NL-1:0] valid;
    state_t state;
    logic [IW-LW-1:0] idx;
    logic [LW-1:0] beat;
    logic poison, rd_hit, wr_hit, wr_fill;
    function automatic logic hit(input logic [AW-1:0] a);
        return valid[a[IW-1:LW]] && tag[a[IW-1:LW]] == a[AW-1:IW];
    endfunction
    assign rd_hit = state != CLEAR && hit(bus.RDA);
    assign wr_hit = bus.WR && state != CLEAR && hit(bus.WRA);
    // A write into the line being fetched makes the fetched copy stale.
    assign wr_fill = bus.WR && (state == REQ || state == DATA || state == COMMIT) &&
                     bus.WRA[AW-1:LW] == bus.FA[AW-1:LW];
    assign bus.BUSY = state != IDLE;
`ifdef PREFETCH_NEXT_EN
    logic pf;
    logic [AW-1:0] nfa;
    assign nfa = bus.FA + AW'(1 << LW);
`endif
    always_ff @(posedge CLK) begin
        if (bus.RDREQ) begin
            bus.RDD <= data[bus.RDA[IW-1:0]];
            bus.Match <= rd_hit;
        end
        if (wr_hit)
            for (int b = 0; b < 4; b++)
                if (bus.WRM[b]) data[bus.WRA[IW-1:0]][8*b +: 8] <= bus.WRD[8*b +: 8];
        if (wr_fill) poison <= 1'b1;
        if (RST || bus.CLR) begin
            state <= CLEAR;
            idx <= '0;
            bus.FREQ <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    valid[idx] <= 1'b0;
                    idx <= idx + 1'b1;
                    if (&idx) state <= IDLE;
                end
                IDLE: if (bus.RDREQ && !rd_hit) begin
                    bus.FA <= {bus.RDA[AW-1:LW], LW'(0)};
                    valid[bus.RDA[IW-1:LW]] <= 1'b0;
                    poison <= 1'b0;
                    bus.FREQ <= 1'b1;
                    state <= REQ;
`ifdef PREFETCH_NEXT_EN
                    pf <= 1'b0;
`endif
                end
                REQ: if (bus.FACK) begin
                    bus.FREQ <= 1'b0;
                    beat <= '0;
                    state <= DATA;
                end
                DATA: if (bus.FDV) begin
                    data[{bus.FA[IW-1:LW], beat}] <= bus.FD;
                    beat <= beat + 1'b1;
                    if (&beat) state <= COMMIT;
                end
                COMMIT: begin
                    tag[bus.FA[IW-1:LW]] <= bus.FA[AW-1:IW];
                    valid[bus.FA[IW-1:LW]] <= !(poison || wr_fill);
`ifdef PREFETCH_NEXT_EN
                    state <= pf ? IDLE : PF;
`else
                    state <= IDLE;
`endif
                end
`ifdef PREFETCH_NEXT_EN
                PF: if (hit(nfa)) state <= IDLE;
                else begin
                    bus.FA <= nfa;
                    valid[nfa[IW-1:LW]] <= 1'b0;
                    poison <= 1'b0;
                    bus.FREQ <= 1'b1;
                    pf <= 1'b1;
                    state <= REQ;
                end
`endif
                default: state <= IDLE;
            endcase
        end
        if (RST) begin
            bus.RDD <= '0;
            bus.Match <= 1'b0;
            bus.FA <= '0;
            poison <= 1'b0;
        end
    end
endmodule

// File: tb/tb_l2_prefetch_buf.sv
// tb_l2_prefetch_buf: directed scenarios for l2_prefetch_buf at AW=26, IW=7, LW=2.
module tb_l2_prefetch_buf;
    logic CLK = 0, RST = 1;
    int errors = 0, checks = 0;
    l2_prefetch_buf_if #(.AW(26)) bus ();
    l2_prefetch_buf #(.AW(26), .IW(7), .LW(2)) dut (.CLK(CLK), .RST(RST), .bus(bus));
    always #5 CLK = ~CLK;
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask
    task automatic look(input logic [25:0] a);
        bus.RDREQ = 1; bus.RDA = a; tick(); bus.RDREQ = 0;
    endtask
    task automatic beats(input logic [31:0] d0);
        for (int i = 0; i < 4; i++) begin
            bus.FDV = 1; bus.FD = d0 + 32'(i); tick();
            if (i == 1) begin bus.FDV = 0; tick(); end
        end
        bus.FDV = 0;
    endtask
    task automatic test_reset();
        tick(); RST = 0;
        checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL rst_match got=%0h exp=0", bus.Match); end
        checks++; if (bus.RDD !== 32'h0) begin errors++; $display("FAIL rst_rdd got=%0h exp=0", bus.RDD); end
        checks++; if (bus.FREQ !== 1'b0) begin errors++; $display("FAIL rst_freq got=%0h exp=0", bus.FREQ); end
        checks++; if (bus.FA !== 26'h0) begin errors++; $display("FAIL rst_fa got=%0h exp=0", bus.FA); end
        bus.RDREQ = 1; bus.RDA = 26'h10;
        for (int i = 0; i < 32; i++) begin
            checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL rst_busy cyc=%0d got=%0h exp=1", i, bus.BUSY); end
            tick();
            checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL rst_lookup cyc=%0d got=%0h exp=0", i, bus.Match); end
        end
        bus.RDREQ = 0;
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy_end got=%0h exp=0", bus.BUSY); end
    endtask
    task automatic test_poison();
        look(26'h104);
        checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL poison_miss got=%0h exp=0", bus.Match); end
        checks++; if (bus.FREQ !== 1'b1) begin errors++; $display("FAIL poison_freq got=%0h exp=1", bus.FREQ); end
        checks++; if (bus.FA !== 26'h104) begin errors++; $display("FAIL poison_fa got=%0h exp=104", bus.FA); end
        bus.FACK = 1; tick(); bus.FACK = 0;
        checks++; if (bus.FREQ !== 1'b0) begin errors++; $display("FAIL poison_ack got=%0h exp=0", bus.FREQ); end
        for (int i = 0; i < 4; i++) begin
            bus.FDV = 1; bus.FD = 32'h50 + 32'(i);
            bus.WR = (i == 1); bus.WRA = 26'h107; bus.WRD = 32'h77777777; bus.WRM = 4'hF;
            tick();
        end
        bus.FDV = 0; bus.WR = 0;
        tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL poison_idle got=%0h exp=0", bus.BUSY); end
        look(26'h107);
        checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL poison_hit got=%0h exp=0", bus.Match); end
        checks++; if (bus.FREQ !== 1'b1) begin errors++; $display("FAIL poison_refill got=%0h exp=1", bus.FREQ); end
        checks++; if (bus.FA !== 26'h104) begin errors++; $display("FAIL poison_refa got=%0h exp=104", bus.FA); end
    endtask
    task automatic test_fill();
        tick();
        checks++; if (bus.FREQ !== 1'b1) begin errors++; $display("FAIL fill_hold got=%0h exp=1", bus.FREQ); end
        bus.FACK = 1; tick(); bus.FACK = 0;
        checks++; if (bus.FREQ !== 1'b0) begin errors++; $display("FAIL fill_ack got=%0h exp=0", bus.FREQ); end
        beats(32'hA0);
        tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL fill_idle got=%0h exp=0", bus.BUSY); end
        look(26'h106);
        checks++; if (bus.Match !== 1'b1) begin errors++; $display("FAIL fill_hit got=%0h exp=1", bus.Match); end
        checks++; if (bus.RDD !== 32'hA2) begin errors++; $display("FAIL fill_rdd106 got=%0h exp=a2", bus.RDD); end
        look(26'h104);
        checks++; if (bus.RDD !== 32'hA0) begin errors++; $display("FAIL fill_rdd104 got=%0h exp=a0", bus.RDD); end
        look(26'h107);
        checks++; if (bus.Match !== 1'b1 || bus.RDD !== 32'hA3) begin errors++; $display("FAIL fill_rdd107 got=%0h/%0h exp=1/a3", bus.Match, bus.RDD); end
    endtask
    task automatic test_fa_align();
        look(26'h20E);
        checks++; if (bus.FA !== 26'h20C) begin errors++; $display("FAIL align_fa got=%0h exp=20c", bus.FA); end
        bus.FACK = 1; tick(); bus.FACK = 0;
        beats(32'hB0);
        tick();
        look(26'h20E);
        checks++; if (bus.Match !== 1'b1 || bus.RDD !== 32'hB2) begin errors++; $display("FAIL align_rdd got=%0h/%0h exp=1/b2", bus.Match, bus.RDD); end
        look(26'h106);
        checks++; if (bus.Match !== 1'b1 || bus.RDD !== 32'hA2) begin errors++; $display("FAIL align_other got=%0h/%0h exp=1/a2", bus.Match, bus.RDD); end
    endtask
    task automatic test_snoop();
        bus.WR = 1; bus.WRA = 26'h105; bus.WRM = 4'b0011; bus.WRD = 32'h1234FFFF; tick(); bus.WR = 0;
        look(26'h105);
        checks++; if (bus.RDD !== 32'h0000FFFF) begin errors++; $display("FAIL snoop_bytes got=%0h exp=ffff", bus.RDD); end
        bus.WR = 1; bus.WRM = 4'b1100; bus.WRD = 32'hBEEF0000;
        bus.RDREQ = 1; bus.RDA = 26'h105; tick(); bus.WR = 0; bus.RDREQ = 0;
        checks++; if (bus.RDD !== 32'h0000FFFF) begin errors++; $display("FAIL snoop_rdw got=%0h exp=ffff", bus.RDD); end
        bus.WR = 1; bus.WRA = 26'h1105; bus.WRM = 4'hF; bus.WRD = 32'hDEADDEAD; tick(); bus.WR = 0;
        look(26'h105);
        checks++; if (bus.RDD !== 32'hBEEFFFFF) begin errors++; $display("FAIL snoop_tagmiss got=%0h exp=beefffff", bus.RDD); end
    endtask
    task automatic sweep();
        bus.CLR = 1; tick(); bus.CLR = 0;
        for (int i = 0; i < 32; i++) tick();
    endtask
    task automatic test_clear();
        look(26'h300);
        checks++; if (bus.FA !== 26'h300) begin errors++; $display("FAIL clr_fa got=%0h exp=300", bus.FA); end
        bus.FACK = 1; tick(); bus.FACK = 0;
        bus.FDV = 1; bus.FD = 32'hC0; tick();
        bus.FD = 32'hC1; tick();
        bus.FD = 32'hC2; bus.CLR = 1; tick(); bus.CLR = 0;
        checks++; if (bus.FREQ !== 1'b0) begin errors++; $display("FAIL clr_freq got=%0h exp=0", bus.FREQ); end
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL clr_busy got=%0h exp=1", bus.BUSY); end
        bus.FD = 32'hC3; bus.RDREQ = 1; bus.RDA = 26'h106; tick(); bus.RDREQ = 0;
        checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL clr_during got=%0h exp=0", bus.Match); end
        bus.FD = 32'hC4; tick(); bus.FDV = 0;
        for (int i = 0; i < 29; i++) tick();
        checks++; if (bus.BUSY !== 1'b1) begin errors++; $display("FAIL clr_sweep_len got=%0h exp=1", bus.BUSY); end
        tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL clr_sweep_end got=%0h exp=0", bus.BUSY); end
        look(26'h20E);
        checks++; if (bus.Match !== 1'b0 || bus.FA !== 26'h20C) begin errors++; $display("FAIL clr_miss20e got=%0h/%0h exp=0/20c", bus.Match, bus.FA); end
        sweep();
        look(26'h106);
        checks++; if (bus.Match !== 1'b0) begin errors++; $display("FAIL clr_miss106 got=%0h exp=0", bus.Match); end
        sweep();
    endtask
`ifdef PREFETCH_NEXT_EN
    task automatic test_prefetch();
        look(26'h200);
        bus.FACK = 1; tick(); bus.FACK = 0;
        beats(32'hD0);
        tick();
        tick();
        checks++; if (bus.FREQ !== 1'b1 || bus.FA !== 26'h204) begin errors++; $display("FAIL pf_req got=%0h/%0h exp=1/204", bus.FREQ, bus.FA); end
        bus.FACK = 1; tick(); bus.FACK = 0;
        beats(32'hE0);
        tick();
        checks++; if (bus.BUSY !== 1'b0) begin errors++; $display("FAIL pf_nochain got=%0h exp=0", bus.BUSY); end
        look(26'h204);
        checks++; if (bus.Match !== 1'b1 || bus.RDD !== 32'hE0) begin errors++; $display("FAIL pf_hit got=%0h/%0h exp=1/e0", bus.Match, bus.RDD); end
        look(26'h203);
        checks++; if (bus.Match !== 1'b1 || bus.RDD !== 32'hD3) begin errors++; $display("FAIL pf_demand got=%0h/%0h exp=1/d3", bus.Match, bus.RDD); end
    endtask
`endif
    initial begin
        {bus.RDREQ, bus.FACK, bus.FDV, bus.WR, bus.CLR} = '0;
        bus.RDA = '0; bus.WRA = '0; bus.FD = '0; bus.WRD = '0; bus.WRM = '0;
        test_reset();
        test_poison();
        test_fill();
        test_fa_align();
        test_snoop();
        test_clear();
`ifdef PREFETCH_NEXT_EN
        test_prefetch();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
